// File: rtl/maze_pkg.sv
// Shared constants and encodings for the maze movement controller:
// grid geometry, dead sentinel, game-state and direction enums.
package maze_pkg;

  localparam int MAZE_W = 18;
  localparam int MAZE_H = 11;
  localparam int MAZE_CELLS = MAZE_W * MAZE_H;
  localparam logic [7:0] DEAD_POS = 8'd255;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DEAD  = 2'd2,
    ST_WIN   = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_e;

  // Pending vector is {UP, DOWN, RIGHT, LEFT}; UP wins, LEFT loses.
  function automatic dir_e pick_dir(input logic [3:0] pend);
    if (pend[3]) return DIR_UP;
    else if (pend[2]) return DIR_DOWN;
    else if (pend[1]) return DIR_RIGHT;
    else if (pend[0]) return DIR_LEFT;
    else return DIR_NONE;
  endfunction

endpackage

// File: rtl/maze_step_calc.sv
// Combinational move evaluator: target cell, grid bounds and wall lookup
// for one direction from the current cell.
module maze_step_calc
  import maze_pkg::*;
#(
  parameter int W = MAZE_W,
  parameter int H = MAZE_H
) (
  input  logic [7:0]     i_pos,
  input  dir_e           i_dir,
  input  logic [W*H-1:0] i_mazestate,
  output logic [8:0]     o_target,
  output logic           o_in_grid,
  output logic           o_open
);

  logic [7:0] w_col;
  logic       w_on_grid;
  logic [7:0] w_idx;

  assign w_col     = i_pos % 8'(W);
  assign w_on_grid = ({1'b0, i_pos} < 9'(W * H));

  // Target is 9 bits wide so UP/LEFT underflow shows up as a large value.
  always_comb begin
    o_target  = {1'b0, i_pos};
    o_in_grid = 1'b0;
    case (i_dir)
      DIR_UP: begin
        o_target  = {1'b0, i_pos} - 9'(W);
        o_in_grid = w_on_grid && (i_pos >= 8'(W));
      end
      DIR_DOWN: begin
        o_target  = {1'b0, i_pos} + 9'(W);
        o_in_grid = w_on_grid && (({1'b0, i_pos} + 9'(W)) < 9'(W * H));
      end
      DIR_RIGHT: begin
        o_target  = {1'b0, i_pos} + 9'd1;
        o_in_grid = w_on_grid && (w_col != 8'(W - 1));
      end
      DIR_LEFT: begin
        o_target  = {1'b0, i_pos} - 9'd1;
        o_in_grid = w_on_grid && (w_col != 8'd0);
      end
      default: ;
    endcase
  end

  assign w_idx  = o_in_grid ? o_target[7:0] : 8'd0;
  assign o_open = o_in_grid && i_mazestate[w_idx];

endmodule

// File: rtl/maze_move_controller.sv
// Player movement sequencer: button latch, per-tick arbitration, position,
// step counter and PAUSE/PLAY/DEAD/WIN FSM. MAZE_WALL_KILL_EN makes walls lethal.
module maze_move_controller #(
  parameter int MAZE_W    = 18,
  parameter int MAZE_H    = 11,
  parameter int START_POS = 181,
  parameter int GOAL_POS  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     move_tick,
  input  logic                     UPbtn,
  input  logic                     DOWNbtn,
  input  logic                     RIGHTbtn,
  input  logic                     LEFTbtn,
  input  logic                     CTRLbtn,
  input  logic [MAZE_W*MAZE_H-1:0] mazestate,
  input  logic [7:0]               begin_spot,
  input  logic                     run,
  output logic [7:0]               pos,
  output logic [1:0]               state,
  output logic                     move_done,
  output logic [9:0]               step_count
);
  import maze_pkg::*;

  game_state_e r_state;
  logic [7:0]  r_pos;
  logic [9:0]  r_steps;
  logic        r_move_done;
  logic [3:0]  r_pend;
  logic [3:0]  r_btn_prev;
  logic        r_ctrl_prev;

  game_state_e w_state_next;
  logic [7:0]  w_pos_next;
  logic [9:0]  w_steps_next;
  logic        w_done_next;
  logic [3:0]  w_pend_next;

  logic [3:0]  w_btns;
  logic [3:0]  w_rise;
  logic [3:0]  w_pend_eff;
  logic        w_ctrl_rise;
  dir_e        w_dir;
  logic [8:0]  w_target;
  logic        w_in_grid;
  logic        w_open;

  assign w_btns      = {UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn};
  assign w_rise      = w_btns & ~r_btn_prev;
  assign w_ctrl_rise = CTRLbtn & ~r_ctrl_prev;
  // A press landing in the tick cycle itself still competes for that tick.
  assign w_pend_eff  = r_pend | w_rise;
  assign w_dir       = pick_dir(w_pend_eff);

  maze_step_calc #(
    .W(MAZE_W),
    .H(MAZE_H)
  ) u_step_calc (
    .i_pos       (r_pos),
    .i_dir       (w_dir),
    .i_mazestate (mazestate),
    .o_target    (w_target),
    .o_in_grid   (w_in_grid),
    .o_open      (w_open)
  );

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_steps_next = r_steps;
    w_done_next  = 1'b0;
    w_pend_next  = w_pend_eff;
    case (r_state)
      ST_PAUSE: begin
        if (run) begin
          w_state_next = ST_PLAY;
          w_pend_next  = '0;
        end
      end
      ST_PLAY: begin
        if (!run) begin
          w_state_next = ST_PAUSE;
          w_pend_next  = '0;
        end else if (move_tick) begin
          w_pend_next = '0;
          if (w_in_grid && w_open) begin
            w_pos_next   = w_target[7:0];
            w_steps_next = (r_steps == 10'h3FF) ? r_steps : r_steps + 10'd1;
            w_done_next  = 1'b1;
            if (w_target == 9'(GOAL_POS)) w_state_next = ST_WIN;
          end
`ifdef MAZE_WALL_KILL_EN
          else if (w_in_grid) begin
            w_pos_next   = DEAD_POS;
            w_state_next = ST_DEAD;
          end
`endif
        end
      end
      ST_DEAD: begin
        if (w_ctrl_rise) begin
          w_state_next = ST_PLAY;
          w_pos_next   = begin_spot;
          w_pend_next  = '0;
        end
      end
      ST_WIN: begin
        if (w_ctrl_rise) begin
          w_state_next = ST_PLAY;
          w_pos_next   = 8'(START_POS);
          w_steps_next = '0;
          w_pend_next  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_PAUSE;
      r_pos       <= 8'(START_POS);
      r_steps     <= '0;
      r_move_done <= 1'b0;
      r_pend      <= '0;
      r_btn_prev  <= '0;
      r_ctrl_prev <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pos       <= w_pos_next;
      r_steps     <= w_steps_next;
      r_move_done <= w_done_next;
      r_pend      <= w_pend_next;
      r_btn_prev  <= w_btns;
      r_ctrl_prev <= CTRLbtn;
    end
  end

  assign pos        = r_pos;
  assign state      = r_state;
  assign move_done  = r_move_done;
  assign step_count = r_steps;

endmodule

// File: tb/tb_maze_move_controller.sv
module tb_maze_move_controller;

  localparam int B_UP    = 8;
  localparam int B_DOWN  = 4;
  localparam int B_RIGHT = 2;
  localparam int B_LEFT  = 1;
  localparam int S_PAUSE = 0;
  localparam int S_PLAY  = 1;
  localparam int S_DEAD  = 2;
  localparam int S_WIN   = 3;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         move_tick;
  logic         UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn, CTRLbtn;
  logic [197:0] mazestate;
  logic [7:0]   begin_spot;
  logic         run;
  logic [7:0]   pos;
  logic [1:0]   state;
  logic         move_done;
  logic [9:0]   step_count;

  typedef struct {
    int    cyc;
    int    pos;
    int    st;
    int    steps;
    int    done;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cur;

  maze_move_controller #(
    .MAZE_W(18), .MAZE_H(11), .START_POS(181), .GOAL_POS(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .move_tick(move_tick),
    .UPbtn(UPbtn), .DOWNbtn(DOWNbtn), .RIGHTbtn(RIGHTbtn), .LEFTbtn(LEFTbtn),
    .CTRLbtn(CTRLbtn), .mazestate(mazestate), .begin_spot(begin_spot), .run(run),
    .pos(pos), .state(state), .move_done(move_done), .step_count(step_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic expect_next(input int p, input int s, input int n, input int d, input string nm);
    exp_t e;
    e.cyc = cyc + 1; e.pos = p; e.st = s; e.steps = n; e.done = d; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic set_btns(input int b);
    UPbtn    = b[3];
    DOWNbtn  = b[2];
    RIGHTbtn = b[1];
    LEFTbtn  = b[0];
  endtask

  task automatic move(input int b, input bit same, input int p, input int s,
                      input int n, input int d, input string nm);
    if (!same) begin
      @(negedge CLK);
      set_btns(b);
      @(negedge CLK);
      set_btns(0);
    end else begin
      @(negedge CLK);
      set_btns(b);
    end
    move_tick = 1'b1;
    expect_next(p, s, n, d, nm);
    @(negedge CLK);
    set_btns(0);
    move_tick = 1'b0;
    expect_next(p, s, n, 0, {nm, "_hold"});
  endtask

  task automatic ctrl_press(input int p, input int s, input int n, input string nm);
    @(negedge CLK);
    CTRLbtn = 1'b1;
    expect_next(p, s, n, 0, nm);
    @(negedge CLK);
    CTRLbtn = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc == cyc && int'(pos) == e.pos && int'(state) == e.st &&
            int'(step_count) == e.steps && int'(move_done) == e.done)
          n_pass++;
        else
          $display("FAIL %s cyc=%0d: got pos=%0d state=%0d steps=%0d done=%0d, expected pos=%0d state=%0d steps=%0d done=%0d (due cyc %0d)",
                   e.name, cyc, pos, state, step_count, move_done,
                   e.pos, e.st, e.steps, e.done, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; move_tick = 1'b0; set_btns(0); CTRLbtn = 1'b0;
    run = 1'b0; begin_spot = 8'd0;
    mazestate = '1;
    mazestate[182] = 1'b0;

    repeat (2) @(negedge CLK);
    expect_next(181, S_PAUSE, 0, 0, "reset");
    @(negedge CLK);
    RESET = 1'b0;
    run = 1'b1;
    expect_next(181, S_PLAY, 0, 0, "pause_to_play");
    @(negedge CLK);

    move(B_DOWN, 0, 181, S_PLAY, 0, 0, "down_row10");
    move(B_UP, 0, 163, S_PLAY, 1, 1, "up_163");
    move(B_DOWN, 0, 181, S_PLAY, 2, 1, "down_181");
    move(B_UP | B_LEFT, 0, 163, S_PLAY, 3, 1, "up_over_left");
    move(0, 0, 163, S_PLAY, 3, 0, "left_cleared");
    for (int i = 1; i <= 7; i++)
      move(B_UP, (i % 2) == 1, 163 - 18 * i, S_PLAY, 3 + i, 1, "up_col1");
    move(B_LEFT, 0, 36, S_PLAY, 11, 1, "left_36");
    move(B_LEFT, 0, 36, S_PLAY, 11, 0, "left_col0");
    move(B_UP, 1, 18, S_PLAY, 12, 1, "up_18");
    move(B_UP, 0, 0, S_PLAY, 13, 1, "up_0");
    move(B_UP, 0, 0, S_PLAY, 13, 0, "up_row0");
    ctrl_press(0, S_PLAY, 13, "ctrl_in_play");

    for (int i = 1; i <= 16; i++)
      move(B_RIGHT, 0, i, (i == 16) ? S_WIN : S_PLAY, 13 + i, 1, "right_row0");
    move(B_DOWN, 0, 16, S_WIN, 29, 0, "tick_in_win");
    @(negedge CLK);
    run = 1'b0;
    expect_next(16, S_WIN, 29, 0, "run0_in_win");
    @(negedge CLK);
    run = 1'b1;
    ctrl_press(181, S_PLAY, 0, "win_restart");

    move(B_LEFT, 0, 180, S_PLAY, 1, 1, "left_180");
    move(B_RIGHT, 0, 181, S_PLAY, 2, 1, "right_181");
`ifdef MAZE_WALL_KILL_EN
    move(B_RIGHT, 0, 255, S_DEAD, 2, 0, "wall_kill");
    move(B_UP, 0, 255, S_DEAD, 2, 0, "tick_in_dead");
    begin_spot = 8'd100;
    ctrl_press(100, S_PLAY, 2, "respawn");
    begin_spot = 8'd0;
    cur = 100;
`else
    move(B_RIGHT, 0, 181, S_PLAY, 2, 0, "wall_block");
    cur = 181;
`endif

    @(negedge CLK);
    LEFTbtn = 1'b1;
    @(negedge CLK);
    LEFTbtn = 1'b0;
    run = 1'b0;
    move_tick = 1'b1;
    expect_next(cur, S_PAUSE, 2, 0, "run0_pause");
    @(negedge CLK);
    move_tick = 1'b0;
    run = 1'b1;
    expect_next(cur, S_PLAY, 2, 0, "resume");
    move(0, 0, cur, S_PLAY, 2, 0, "no_stale_move");

    for (int i = 0; i < 1030; i++)
      move(((i % 2) == 0) ? B_LEFT : B_RIGHT, 0, ((i % 2) == 0) ? cur - 1 : cur,
           S_PLAY, (3 + i > 1023) ? 1023 : 3 + i, 1, "step_sat");

    repeat (3) @(negedge CLK);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: never compared, expected pos=%0d state=%0d", e.name, e.pos, e.st);
    end

    n_checks++;
    if (int'(pos) == cur) begin
      n_pass++;
      $display("PASS final_pos: pos=%0d", pos);
    end else
      $display("FAIL final_pos: got pos=%0d expected %0d", pos, cur);

    n_checks++;
    if (int'(state) == S_PLAY) begin
      n_pass++;
      $display("PASS final_state: state=%0d", state);
    end else
      $display("FAIL final_state: got state=%0d expected %0d", state, S_PLAY);

    n_checks++;
    if (step_count == 10'd1023) begin
      n_pass++;
      $display("PASS final_steps_saturated: steps=%0d", step_count);
    end else
      $display("FAIL final_steps_saturated: got steps=%0d expected 1023", step_count);

    n_checks++;
    if (move_done == 1'b0) begin
      n_pass++;
      $display("PASS final_idle_done: done=%0d", move_done);
    end else
      $display("FAIL final_idle_done: got done=%0d expected 0", move_done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
